// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline datapath.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/next_pc_sel.sv
// Next-PC selection: jr > jump > taken branch > sequential. Purely combinational.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] if_id_pc_plus4,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [WORD_W-1:0] jr_target,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] branch_disp;
    logic [WORD_W-1:0] branch_target;
    logic [WORD_W-1:0] jump_target;
    logic [WORD_W-1:0] jr_aligned;

    // Candidate targets; jr target is word-aligned by masking the low bits.
    always_comb begin
        pc_plus4      = pc + WORD_W'(4);
        branch_disp   = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        branch_target = if_id_pc_plus4 + branch_disp;
        jump_target   = {if_id_pc_plus4[31:28], jump_index, 2'b00};
        jr_aligned    = jr_target & ~WORD_W'(3);
    end

    // Priority mux over the redirect sources.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_aligned;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule : next_pc_sel

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register and stall/flush counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned  CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              if_id_clear,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [31:0]       jr_target,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [WORD_W-1:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] next_pc;
    logic              stall_evt;

    next_pc_sel u_next_pc_sel (
        .pc             (pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump           (jump),
        .jump_index     (jump_index),
        .jr             (jr),
        .jr_target      (jr_target),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc)
    );

    assign imem_addr = pc;
    assign stall_evt = !pc_write && !if_id_write && !if_id_clear;

    // PC register; redirects while pc_write is low are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC_ALIGNED;
        end else if (pc_write) begin
            pc <= next_pc;
        end
    end

    // IF/ID register; a clear beats a write and inserts a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (if_id_clear) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (if_id_write) begin
            if_id_instr    <= imem_rdata;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

    // Stall and flush event counters, free-running with wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_evt) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (if_id_clear) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule : fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register, and acts on the stall/flush controls issued by the hazard unit. Selects the next PC from sequential, branch, jump and jump-register sources resolved in ID. Drives the combinational instruction-memory address. Keeps stall and flush event counters for performance debug.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, 32: width of the event counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_write`  in  1  from hazard unit; 1 = PC may update this cycle.
- `if_id_write`  in  1  from hazard unit; 1 = IF/ID may capture.
- `if_id_clear`  in  1  from hazard unit; 1 = load bubble into IF/ID.
- `branch_taken`  in  1  ID-stage branch resolved taken.
- `branch_offset`  in  16  branch immediate from the ID instruction.
- `jump`  in  1  ID-stage j/jal.
- `jump_index`  in  26  instr_index field of the ID instruction.
- `jr`  in  1  ID-stage jr/jalr.
- `jr_target`  in  32  forwarded rs value.
- `imem_addr`  out  32  instruction-memory address (= PC).
- `imem_rdata`  in  32  instruction at `imem_addr`, valid in the same cycle.
- `if_id_instr`  out  32  instruction held in IF/ID.
- `if_id_pc_plus4`  out  32  PC+4 of that instruction.
- `if_id_valid`  out  1  1 = IF/ID holds a real instruction.
- `stall_count`  out  CNT_W  cycles stalled.
- `flush_count`  out  CNT_W  flushes performed.

## Operation
- `imem_addr` = PC, combinational. `pc_plus4` = PC + 4, mod 2^32.
- Next-PC priority: `jr` > `jump` > `branch_taken` > `pc_plus4`.
  - jr: {`jr_target`[31:2], 2'b00}.
  - jump: {`if_id_pc_plus4`[31:28], `jump_index`, 2'b00}.
  - branch: `if_id_pc_plus4` + (sign-extended `branch_offset` << 2), mod 2^32.
- PC: loads next-PC when `pc_write`=1 and holds otherwise. A redirect asserted while `pc_write`=0 is ignored; the hazard unit re-presents it in a later cycle. PC[1:0] is always 00.
- IF/ID update, in priority order:
  - `if_id_clear`=1: instr <= 32'h0 (NOP), pc_plus4 <= 0, valid <= 0. This takes effect regardless of `if_id_write`.
  - else `if_id_write`=1: instr <= `imem_rdata`, pc_plus4 <= `pc_plus4`, valid <= 1.
  - else: hold all three.
- `stall_count`: +1 in each cycle with `pc_write`=0, `if_id_write`=0 and `if_id_clear`=0.
- `flush_count`: +1 in each cycle with `if_id_clear`=1.
- Both counters wrap modulo 2^CNT_W.
- Reset (`reset`=0, asynchronous): PC = `RESET_PC`, IF/ID instr/pc_plus4 = 0, valid = 0, both counters = 0. Reset asserted mid-stall or mid-flush overrides everything immediately. First capture happens on the first rising edge after deassertion.

## Timing
- The instruction at PC appears on `if_id_instr` one clock after PC holds that value (`if_id_write`=1).
- Redirect latency: a redirect asserted in cycle N makes PC = target in N+1. The wrong-path instruction fetched in N is killed only if `if_id_clear`=1 in N.
- Load-use stall: PC and IF/ID both hold for exactly the cycles in which the hazard unit deasserts `pc_write`/`if_id_write`.
- Simultaneous `if_id_clear`=1 and `pc_write`=1 (jump, taken branch): PC redirects and IF/ID becomes a bubble on the same edge.
- All outputs are registered except `imem_addr`, which is a direct copy of the PC register.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR` = 32'h0, default `RESET_PC`, and the word-width constant 32.
- One combinational sub-module, `next_pc_sel`. Inputs: PC, `if_id_pc_plus4`, redirect requests and operands. Output: next-PC. Kept separate so it can be reused by the single-cycle datapath.
- The PC register, IF/ID register and counters stay in `fetch_stage`.

## Test plan
- Reset release with `RESET_PC`=0, constant `pc_write`=`if_id_write`=1, imem returning address|0xA000_0000 → `imem_addr` 0,4,8,…; `if_id_instr` = 0xA000_0000 one cycle later with `if_id_pc_plus4`=4 and valid=1.
- Load-use stall: drop `pc_write`/`if_id_write` for 1 cycle at PC=0x10 → PC stays 0x10 for 2 cycles, IF/ID holds the 0x0C instruction, `stall_count`=1.
- Jump: `if_id_pc_plus4`=0x4000_0008, `jump_index`=0x0000100, `jump`=1, `if_id_clear`=1 → PC=0x4000_0400 next cycle, IF/ID=NOP with valid=0, `flush_count`=1.
- Backward branch: `if_id_pc_plus4`=0x20, offset 16'hFFFC, `branch_taken`=1 → PC=0x10. With `jr`=1 and `jr_target`=0x103 asserted in the same cycle → PC=0x100, since jr has priority and the low bits are forced to 00.
- Branch stall: `branch_taken`=1 with `pc_write`=0 → PC holds. Branch re-presented with `pc_write`=1 next cycle → redirect taken.
- Reset asserted during a stall with `stall_count`=5 → all outputs return to their reset values asynchronously, before the next clock edge.
